// File: rtl/axi4_rrch_arbiter.sv
// Read-response channel arbiter: round-robin, burst-atomic sharing of the slave R channel
// between forwarded master bursts and locally generated SLVERR bursts. Option: AXI4_RRCH_ARB_DROP_CNT_EN.
module axi4_rrch_arbiter #(
    parameter int C_AXI_DATA_WIDTH  = 32,
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_USER_WIDTH  = 4,
    parameter int C_DROP_FIFO_DEPTH = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arst,
    input  logic                        drop_valid,
    input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
    input  logic [7:0]                  drop_len,
    output logic                        drop_ready,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic                        m_axi4_rlast,
    input  logic                        m_axi4_rvalid,
    input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
    output logic                        m_axi4_rready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [1:0]                  s_axi4_rresp,
    output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic                        s_axi4_rlast,
    output logic                        s_axi4_rvalid,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
    input  logic                        s_axi4_rready
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt,
    input  logic                        drop_cnt_clr
`endif
);

    localparam int AW = $clog2(C_DROP_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(C_DROP_FIFO_DEPTH);

    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0] id;
        logic [7:0]                len;
    } drop_req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

    drop_req_t   fifo_mem [C_DROP_FIFO_DEPTH];
    drop_req_t   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fill;
    logic        full, empty, push, pop;

    state_t      state, state_nxt;
    logic        last_drop;
    logic [7:0]  beat_cnt;
    logic        grant_fwd, grant_drop;

    assign head       = fifo_mem[rd_ptr];
    assign full       = (fill == DEPTH_L);
    assign empty      = (fill == '0);
    assign drop_ready = !full;
    // Push is gated on full alone, so a same-cycle pop never frees a slot early.
    assign push       = drop_valid && !full;
    assign pop        = (state == ST_DROP) && s_axi4_rready && (beat_cnt == 8'd0);

    always_ff @(posedge axi4_aclk) begin
        if (push) fifo_mem[wr_ptr] <= '{id: drop_id, len: drop_len};
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            state     <= ST_IDLE;
            last_drop <= 1'b0;
            beat_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (grant_drop) begin
                last_drop <= 1'b1;
                beat_cnt  <= head.len;
            end else if (grant_fwd) begin
                last_drop <= 1'b0;
            end else if (state == ST_DROP && s_axi4_rready && beat_cnt != 8'd0) begin
                beat_cnt <= beat_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_fwd     = 1'b0;
        grant_drop    = 1'b0;
        s_axi4_rid    = '0;
        s_axi4_rresp  = 2'b00;
        s_axi4_rdata  = '0;
        s_axi4_rlast  = 1'b0;
        s_axi4_rvalid = 1'b0;
        s_axi4_ruser  = '0;
        m_axi4_rready = 1'b0;
        case (state)
            ST_IDLE: begin
                // On contention the source that did not win last time goes first.
                if (m_axi4_rvalid && !empty) begin
                    grant_fwd  = last_drop;
                    grant_drop = !last_drop;
                end else begin
                    grant_fwd  = m_axi4_rvalid;
                    grant_drop = !empty;
                end
                if (grant_fwd)  state_nxt = ST_FWD;
                if (grant_drop) state_nxt = ST_DROP;
            end
            ST_FWD: begin
                s_axi4_rid    = m_axi4_rid;
                s_axi4_rresp  = m_axi4_rresp;
                s_axi4_rdata  = m_axi4_rdata;
                s_axi4_rlast  = m_axi4_rlast;
                s_axi4_rvalid = m_axi4_rvalid;
                s_axi4_ruser  = m_axi4_ruser;
                m_axi4_rready = s_axi4_rready;
                if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                s_axi4_rvalid = 1'b1;
                s_axi4_rid    = head.id;
                s_axi4_rresp  = 2'b10;
                s_axi4_rlast  = (beat_cnt == 8'd0);
                if (pop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst)                        drop_cnt <= 16'd0;
        else if (drop_cnt_clr)                drop_cnt <= 16'd0;
        else if (pop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi4_rrch_arbiter.sv
// Bench for axi4_rrch_arbiter: vector table, directed corner sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_axi4_rrch_arbiter;
    localparam int DW = 32, IW = 4, UW = 4, DEPTH = 4;

    logic          axi4_aclk = 1'b0;
    logic          axi4_arst = 1'b1;
    logic          drop_valid = 1'b0;
    logic [IW-1:0] drop_id = '0;
    logic [7:0]    drop_len = '0;
    logic          drop_ready;
    logic [IW-1:0] m_axi4_rid = '0;
    logic [1:0]    m_axi4_rresp = '0;
    logic [DW-1:0] m_axi4_rdata = '0;
    logic          m_axi4_rlast = 1'b0;
    logic          m_axi4_rvalid = 1'b0;
    logic [UW-1:0] m_axi4_ruser = '0;
    logic          m_axi4_rready;
    logic [IW-1:0] s_axi4_rid;
    logic [1:0]    s_axi4_rresp;
    logic [DW-1:0] s_axi4_rdata;
    logic          s_axi4_rlast;
    logic          s_axi4_rvalid;
    logic [UW-1:0] s_axi4_ruser;
    logic          s_axi4_rready = 1'b0;
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
    logic [15:0]   drop_cnt;
    logic          drop_cnt_clr = 1'b0;
`endif

    always #5 axi4_aclk = ~axi4_aclk;

    axi4_rrch_arbiter #(
        .C_AXI_DATA_WIDTH(DW), .C_AXI_ID_WIDTH(IW), .C_AXI_USER_WIDTH(UW), .C_DROP_FIFO_DEPTH(DEPTH)
    ) dut (
        .axi4_aclk(axi4_aclk), .axi4_arst(axi4_arst),
        .drop_valid(drop_valid), .drop_id(drop_id), .drop_len(drop_len), .drop_ready(drop_ready),
        .m_axi4_rid(m_axi4_rid), .m_axi4_rresp(m_axi4_rresp), .m_axi4_rdata(m_axi4_rdata),
        .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_ruser(m_axi4_ruser),
        .m_axi4_rready(m_axi4_rready),
        .s_axi4_rid(s_axi4_rid), .s_axi4_rresp(s_axi4_rresp), .s_axi4_rdata(s_axi4_rdata),
        .s_axi4_rlast(s_axi4_rlast), .s_axi4_rvalid(s_axi4_rvalid), .s_axi4_ruser(s_axi4_ruser),
        .s_axi4_rready(s_axi4_rready)
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt), .drop_cnt_clr(drop_cnt_clr)
`endif
    );

    typedef struct packed {
        logic sv; logic [IW-1:0] rid; logic [1:0] rresp; logic [DW-1:0] rdata;
        logic rlast; logic [UW-1:0] ruser; logic mr; logic dr;
    } out_t;

    typedef struct {
        logic dv; logic [IW-1:0] did; logic [7:0] dlen;
        logic mv; logic [IW-1:0] mid; logic [1:0] mresp; logic [DW-1:0] mdata; logic ml; logic [UW-1:0] mu;
        logic sr; out_t exp;
    } vec_t;

    typedef struct { logic [IW-1:0] id; int len; } dreq_t;

    int n_vec = 0, n_err = 0;

    // Reference model: pending drops in a queue, current burst owner (0 none, 1 master, 2 drop)
    dreq_t mq[$];
    int    m_own, m_rem, m_dcnt;
    bit    m_lastd;

    bit         g_mhs, g_shs, g_slast;
    logic [1:0] g_sresp;
    int         mbeat;

    function automatic out_t mk_o(logic sv, logic [IW-1:0] rid, logic [1:0] rresp, logic [DW-1:0] rdata,
                                  logic rlast, logic [UW-1:0] ruser, logic mr, logic dr);
        out_t o;
        o = {sv, rid, rresp, rdata, rlast, ruser, mr, dr};
        return o;
    endfunction

    function automatic vec_t mk_v(logic dv, logic [IW-1:0] did, logic [7:0] dlen, logic mv, logic [IW-1:0] mid,
                                  logic [1:0] mresp, logic [DW-1:0] mdata, logic ml, logic [UW-1:0] mu,
                                  logic sr, out_t e);
        vec_t v;
        v.dv = dv; v.did = did; v.dlen = dlen; v.mv = mv; v.mid = mid; v.mresp = mresp;
        v.mdata = mdata; v.ml = ml; v.mu = mu; v.sr = sr; v.exp = e;
        return v;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o = {s_axi4_rvalid, s_axi4_rid, s_axi4_rresp, s_axi4_rdata, s_axi4_rlast, s_axi4_ruser,
             m_axi4_rready, drop_ready};
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o = '0;
        o.dr = (mq.size() < DEPTH);
        if (m_own == 1) begin
            o.sv = m_axi4_rvalid; o.rid = m_axi4_rid; o.rresp = m_axi4_rresp; o.rdata = m_axi4_rdata;
            o.rlast = m_axi4_rlast; o.ruser = m_axi4_ruser; o.mr = s_axi4_rready;
        end else if (m_own == 2) begin
            o.sv = 1'b1; o.rid = mq[0].id; o.rresp = 2'b10; o.rlast = (m_rem == 0);
        end
        return o;
    endfunction

    task automatic model_reset();
        mq.delete(); m_own = 0; m_rem = 0; m_dcnt = 0; m_lastd = 1'b0;
    endtask

    task automatic model_step();
        bit pop, push;
        dreq_t r;
        pop  = (m_own == 2) && s_axi4_rready && (m_rem == 0);
        push = drop_valid && (mq.size() < DEPTH);
        case (m_own)
            0: begin
                if (m_axi4_rvalid && mq.size() > 0) m_own = m_lastd ? 1 : 2;
                else if (m_axi4_rvalid)             m_own = 1;
                else if (mq.size() > 0)             m_own = 2;
                if (m_own == 1) m_lastd = 1'b0;
                if (m_own == 2) begin m_lastd = 1'b1; m_rem = mq[0].len; end
            end
            1: if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) m_own = 0;
            default: if (s_axi4_rready) begin
                if (m_rem == 0) m_own = 0; else m_rem--;
            end
        endcase
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
        if (drop_cnt_clr) m_dcnt = 0;
        else if (pop && m_dcnt < 65535) m_dcnt++;
`endif
        if (pop) mq.delete(0);
        if (push) begin r.id = drop_id; r.len = int'(drop_len); mq.push_back(r); end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input out_t exp, input string nm);
        @(negedge axi4_aclk);
        chk(nm, 128'(dut_out()), 128'(exp));
        g_mhs = m_axi4_rvalid && m_axi4_rready;
        g_shs = s_axi4_rvalid && s_axi4_rready;
        g_slast = s_axi4_rlast;
        g_sresp = s_axi4_rresp;
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
        chk({nm, "_cnt"}, 128'(drop_cnt), 128'(m_dcnt));
`endif
        @(posedge axi4_aclk);
        model_step();
        #1;
    endtask

    task automatic mcyc(input string nm);
        cyc(model_out(), nm);
    endtask

    task automatic do_reset();
        drop_valid = 0; m_axi4_rvalid = 0; m_axi4_rlast = 0; s_axi4_rready = 0; mbeat = 0;
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
        drop_cnt_clr = 0;
`endif
        axi4_arst = 1; model_reset();
        @(negedge axi4_aclk);
        chk("reset_outputs", 128'(dut_out()), 128'(mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        @(posedge axi4_aclk); #1;
        axi4_arst = 0;
    endtask

    // AXI-legal master: holds a beat until it is accepted, then advances the burst.
    task automatic master_next(input int p_start, input int lo, input int hi);
        if (m_axi4_rvalid && g_mhs) begin
            if (m_axi4_rlast) m_axi4_rvalid = 0;
            else begin mbeat--; m_axi4_rlast = (mbeat == 0); m_axi4_rdata = $urandom; end
        end
        if (!m_axi4_rvalid && $urandom_range(99) < p_start) begin
            mbeat = $urandom_range(hi, lo);
            m_axi4_rvalid = 1; m_axi4_rlast = (mbeat == 0);
            m_axi4_rid = IW'($urandom); m_axi4_rdata = $urandom;
            m_axi4_ruser = UW'($urandom); m_axi4_rresp = 2'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        out_t cap;
        logic [31:0] ord;
        int nb, nd;
        bit seen;

        // Drop-only burst, then two master bursts (one stalled)
        tbl.push_back(mk_v(1, 3, 3, 0, 0, 0, 0, 0, 0, 1, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(1, 3, 2, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(1, 3, 2, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(1, 3, 2, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(1, 3, 2, 0, 1, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 1, 9, 1, 32'hA5A50001, 1, 5, 1, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 1, 9, 1, 32'hA5A50001, 1, 5, 1, mk_o(1, 9, 1, 32'hA5A50001, 1, 5, 1, 1)));
        tbl.push_back(mk_v(0, 0, 0, 1, 2, 0, 32'h00001234, 1, 7, 0, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 1, 2, 0, 32'h00001234, 1, 7, 0, mk_o(1, 2, 0, 32'h00001234, 1, 7, 0, 1)));
        tbl.push_back(mk_v(0, 0, 0, 1, 2, 0, 32'h00001234, 1, 7, 1, mk_o(1, 2, 0, 32'h00001234, 1, 7, 1, 1)));
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_o(0, 0, 0, 0, 0, 0, 0, 1)));

        do_reset();
        foreach (tbl[i]) begin
            drop_valid = tbl[i].dv; drop_id = tbl[i].did; drop_len = tbl[i].dlen;
            m_axi4_rvalid = tbl[i].mv; m_axi4_rid = tbl[i].mid; m_axi4_rresp = tbl[i].mresp;
            m_axi4_rdata = tbl[i].mdata; m_axi4_rlast = tbl[i].ml; m_axi4_ruser = tbl[i].mu;
            s_axi4_rready = tbl[i].sr;
            cyc(tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Contention: two queued drops vs back-to-back 2-beat master bursts
        do_reset();
        s_axi4_rready = 1;
        drop_valid = 1; drop_id = 1; drop_len = 0; mcyc("rr_push");
        drop_id = 2; mcyc("rr_push");
        drop_valid = 0;
        ord = 0; nb = 0;
        for (int i = 0; i < 40 && nb < 4; i++) begin
            master_next(100, 1, 1);
            mcyc("rr");
            if (g_shs && g_slast) begin
                ord = {ord[23:0], (g_sresp == 2'b10) ? 8'h44 : 8'h46};
                nb++;
            end
        end
        chk("rr_order", 128'(ord), 128'(32'h44464446));

        // Backpressure in the middle of a 3-beat drop
        do_reset();
        s_axi4_rready = 1; nb = 0;
        drop_valid = 1; drop_id = 6; drop_len = 2; mcyc("bp");
        drop_valid = 0; mcyc("bp");
        mcyc("bp"); nb += int'(g_shs);
        s_axi4_rready = 0;
        cap = dut_out();
        chk("bp_beat2", 128'(cap), 128'(mk_o(1, 6, 2, 0, 0, 0, 0, 1)));
        for (int i = 0; i < 5; i++) begin
            mcyc("bp_stall"); nb += int'(g_shs);
            chk("bp_stable", 128'(dut_out()), 128'(cap));
        end
        s_axi4_rready = 1;
        for (int i = 0; i < 8; i++) begin mcyc("bp"); nb += int'(g_shs); end
        chk("bp_beats", 128'(nb), 128'(3));

        // FIFO fill while a long master burst holds the channel
        do_reset();
        s_axi4_rready = 1;
        m_axi4_rvalid = 1; m_axi4_rlast = 0; m_axi4_rid = 4'hC; m_axi4_rdata = 32'hDEAD0000;
        mcyc("full");
        for (int i = 0; i < 5; i++) begin
            drop_valid = 1; drop_id = IW'(i); drop_len = 0;
            mcyc("full");
            if (i == 3) chk("full_ready", 128'(drop_ready), 128'(0));
        end
        drop_valid = 0;
        m_axi4_rlast = 1; mcyc("full_mlast");
        m_axi4_rvalid = 0; m_axi4_rlast = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            mcyc("full_drain");
            if (g_shs && g_slast && g_sresp == 2'b10) nd++;
        end
        chk("full_drops", 128'(nd), 128'(4));

        // Maximum length drop
        do_reset();
        s_axi4_rready = 1; nb = 0;
        drop_valid = 1; drop_id = 4'hA; drop_len = 8'd255; mcyc("len255");
        drop_valid = 0;
        for (int i = 0; i < 300; i++) begin mcyc("len255"); nb += int'(g_shs); end
        chk("len255_beats", 128'(nb), 128'(256));

        // Asynchronous reset on beat 2 of an 8-beat drop
        do_reset();
        s_axi4_rready = 1;
        drop_valid = 1; drop_id = 5; drop_len = 7; mcyc("rst");
        drop_valid = 0; mcyc("rst");
        mcyc("rst");
        @(negedge axi4_aclk);
        chk("rst_beat2", 128'(dut_out()), 128'(model_out()));
        #1 axi4_arst = 1;
        #1 chk("rst_async_rvalid", 128'(s_axi4_rvalid), 128'(0));
        model_reset();
        chk("rst_state", 128'(dut_out()), 128'(mk_o(0, 0, 0, 0, 0, 0, 0, 1)));
        @(posedge axi4_aclk); #1;
        axi4_arst = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin mcyc("rst_after"); nb += int'(g_shs); end
        chk("rst_nobeats", 128'(nb), 128'(0));

`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
        // Completion counter and clear priority
        do_reset();
        s_axi4_rready = 1;
        for (int i = 0; i < 3; i++) begin drop_valid = 1; drop_id = IW'(i); drop_len = 0; mcyc("cnt"); end
        drop_valid = 0;
        for (int i = 0; i < 8; i++) mcyc("cnt");
        chk("cnt_three", 128'(drop_cnt), 128'(3));
        drop_valid = 1; drop_len = 1; mcyc("cnt");
        drop_valid = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (s_axi4_rvalid && s_axi4_rlast) seen = 1; else mcyc("cnt");
        end
        chk("cnt_final_seen", 128'(seen), 128'(1));
        drop_cnt_clr = 1; mcyc("cnt_clr");
        drop_cnt_clr = 0;
        chk("cnt_clr_wins", 128'(drop_cnt), 128'(0));
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drop_valid = ($urandom_range(3) == 0);
            drop_id = IW'($urandom);
            drop_len = 8'($urandom_range(4));
            s_axi4_rready = ($urandom_range(3) != 0);
`ifdef AXI4_RRCH_ARB_DROP_CNT_EN
            drop_cnt_clr = ($urandom_range(49) == 0);
`endif
            master_next(30, 0, 3);
            mcyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_rrch_arbiter.md
Name: axi4_rrch_arbiter

Overview:
- Read-response channel arbiter placed between the RAB master-side R channel and the slave-side R channel.
- Shares the slave-side R channel between two sources: forwarded master bursts, and locally generated error bursts for transactions the RAB has dropped.
- Each drop request carries the burst length, so every drop produces a full-length error burst (len+1 beats).
- Arbitration is round-robin and burst-atomic: a burst is never interleaved once granted.

Parameters:
- C_AXI_DATA_WIDTH, 32, R data width
- C_AXI_ID_WIDTH, 4, R ID width
- C_AXI_USER_WIDTH, 4, R user width
- C_DROP_FIFO_DEPTH, 4, drop-request FIFO entries; power of two, minimum 2

Ports:
- axi4_aclk  in  1  clock
- axi4_arst  in  1  reset, asynchronous, active-high
- drop_valid  in  1  drop request valid
- drop_id  in  C_AXI_ID_WIDTH  ID of dropped transaction
- drop_len  in  8  AXI ARLEN of dropped transaction (beats-1)
- drop_ready  out  1  FIFO can accept a request
- m_axi4_rid/rresp/rdata/rlast/rvalid/ruser  in  ID/2/DATA/1/1/USER  master-side R channel
- m_axi4_rready  out  1  master-side ready
- s_axi4_rid/rresp/rdata/rlast/rvalid/ruser  out  ID/2/DATA/1/1/USER  slave-side R channel
- s_axi4_rready  in  1  slave-side ready

Behaviour:
- Reset (async, active-high, also mid-burst):
  - FSM goes to IDLE; FIFO is flushed; beat counter = 0; last_grant = FWD.
  - Outputs: s_axi4_rvalid=0, m_axi4_rready=0, drop_ready=1; all other s_ outputs 0.
  - A burst in progress at reset is abandoned without further beats.
- Drop FIFO:
  - Push when drop_valid && drop_ready; drop_ready = !full.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push into an empty FIFO is visible to the FSM on the next cycle.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - s_axi4_rvalid=0, m_axi4_rready=0.
  - Requesters: req_fwd = m_axi4_rvalid; req_drop = FIFO not empty.
  - Only one requester: grant it.
  - Both: grant the one not equal to last_grant (round-robin).
  - On grant, register last_grant. For DROP, also load beat counter = head.drop_len.
  - Next state is FWD or DROP. This costs a one-cycle arbitration bubble per burst.
- FWD:
  - All s_ signals pass through from m_; m_axi4_rready = s_axi4_rready.
  - On the beat with m_axi4_rvalid && s_axi4_rready && m_axi4_rlast, go to IDLE.
  - Drop requests queue meanwhile.
- DROP:
  - s_axi4_rvalid=1; m_axi4_rready=0.
  - s_axi4_rid = FIFO head id; rresp = 2'b10 (SLVERR); rdata = 0; ruser = 0.
  - s_axi4_rlast = (counter == 0).
  - Each handshake with s_axi4_rready: decrement counter.
  - Handshake at counter==0: pop FIFO, go to IDLE.
  - drop_len=0 gives one beat with rlast=1; drop_len=255 gives 256 beats.
  - Counter is 8-bit and never wraps: it is only decremented when nonzero.
- Stall: while s_axi4_rready=0, every s_ output stays stable (AXI rule).
- Simultaneous push and pop (FIFO not full): both take effect; occupancy unchanged.

Optional Feature:
- Macro AXI4_RRCH_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt (16 bits) counting completed drop bursts (final-beat handshakes).
  - Saturates at 16'hFFFF; reset value 0.
  - Adds input drop_cnt_clr (1 bit), which synchronously zeroes the counter. Clear takes priority over a same-cycle increment.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Drop only: push id=3, len=3 with s_rready=1 → IDLE bubble, then 4 beats with rid=3, rresp=2'b10, rdata=0; rlast only on the 4th; drop_ready stays 1.
- Contention: m_rvalid bursts of 2 beats continuously, plus 2 queued drops (len=0) → after reset order is DROP, FWD, DROP, FWD; no burst interleaved.
- Backpressure: during a len=2 drop, hold s_rready=0 for 5 cycles mid-burst → s_ outputs stable; exactly 3 beats total; counter reaches 0 only on the final handshake.
- FIFO full: push 4 requests while a long FWD burst blocks → drop_ready=0 after the 4th; a 5th drop_valid is not accepted; drop_ready returns to 1 the cycle after the first pop.
- Reset mid-burst: assert axi4_arst on beat 2 of a len=7 drop → s_rvalid=0 immediately (async); after release, FSM is in IDLE, FIFO empty, no further drop beats.
- With AXI4_RRCH_ARB_DROP_CNT_EN: complete 3 drops → drop_cnt=3; pulse drop_cnt_clr in the same cycle as a 4th completion → drop_cnt=0.
